// File: rtl/pong_tone_seq.sv
// pong_tone_seq: sound-effect sequencer for the Pong game.
// A start request plays a burst of square-wave beeps. Each beep has a
// programmable tone half-period, an on-time in milliseconds and a gap in
// milliseconds. A one-cycle done pulse follows the last beep.
// The ms prescaler, tone divider and ms counter all restart on every state
// entry, so every phase length is an exact whole number of milliseconds.
module pong_tone_seq #(
   parameter int CLK_HZ = 100_000_000,
   parameter int DIV_W  = 17,
   parameter int DUR_W  = 10,
   parameter int REP_W  = 3
) (
   input  logic             clk_100MHz,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [DIV_W-1:0] i_half_period,
   input  logic [DUR_W-1:0] i_on_ms,
   input  logic [DUR_W-1:0] i_off_ms,
   input  logic [REP_W-1:0] i_repeat,
   output logic             o_tone,
   output logic             o_busy,
   output logic             o_done
);

   // Clock cycles per millisecond, and the prescaler that counts them
   localparam int              MS_CYCLES = CLK_HZ / 1000;
   localparam int              PRE_W     = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(MS_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [PRE_W-1:0] pre_cnt;
   logic [PRE_W-1:0] pre_next;
   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_next;
   logic [DUR_W-1:0] ms_cnt;
   logic [DUR_W-1:0] ms_next;
   logic [REP_W-1:0] beep_cnt;
   logic [REP_W-1:0] beep_next;

   logic [DIV_W-1:0] half_lat;
   logic [DUR_W-1:0] on_lat;
   logic [DUR_W-1:0] off_lat;

   logic [DIV_W-1:0] half_eff;
   logic [DUR_W-1:0] on_eff;
   logic [REP_W-1:0] rep_eff;

   logic             tick;
   logic             div_wrap;
   logic             on_last_ms;
   logic             gap_last_ms;
   logic             more_beeps;
   logic             accept;
   logic             tone_next;
   logic             done_next;

   // Zero-valued fields that cannot be zero are promoted to one before latching
   always_comb begin
      half_eff = (i_half_period == '0) ? DIV_W'(1) : i_half_period;
      on_eff   = (i_on_ms == '0)       ? DUR_W'(1) : i_on_ms;
      rep_eff  = (i_repeat == '0)      ? REP_W'(1) : i_repeat;
   end

   // Decode the end-of-millisecond, end-of-half-period and end-of-phase conditions
   always_comb begin
      tick        = (pre_cnt == PRE_MAX);
      div_wrap    = (div_cnt == (half_lat - DIV_W'(1)));
      on_last_ms  = tick && (ms_cnt == (on_lat - DUR_W'(1)));
      gap_last_ms = tick && (ms_cnt == (off_lat - DUR_W'(1)));
      more_beeps  = (beep_cnt > REP_W'(1));
   end

   // Next-state and datapath update for the IDLE / ON / GAP sequencer
   always_comb begin
      state_next = state;
      pre_next   = tick ? '0 : (pre_cnt + PRE_W'(1));
      div_next   = div_cnt;
      ms_next    = ms_cnt;
      beep_next  = beep_cnt;
      tone_next  = o_tone;
      done_next  = 1'b0;
      accept     = 1'b0;

      case (state)
         IDLE: begin
            tone_next = 1'b0;
            pre_next  = '0;
            div_next  = '0;
            ms_next   = '0;
            if (i_start) begin
               accept     = 1'b1;
               beep_next  = rep_eff;
               state_next = ON;
            end
         end

         ON: begin
            if (div_wrap) begin
               div_next  = '0;
               tone_next = ~o_tone;
            end else begin
               div_next = div_cnt + DIV_W'(1);
            end

            if (tick) begin
               ms_next = ms_cnt + DUR_W'(1);
            end

            if (on_last_ms) begin
               ms_next   = '0;
               pre_next  = '0;
               div_next  = '0;
               tone_next = 1'b0;
               beep_next = beep_cnt - REP_W'(1);
               if (more_beeps) begin
                  state_next = (off_lat != '0) ? GAP : ON;
               end else begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end
            end
         end

         GAP: begin
            tone_next = 1'b0;
            div_next  = '0;
            if (tick) begin
               ms_next = ms_cnt + DUR_W'(1);
            end
            if (gap_last_ms) begin
               ms_next    = '0;
               pre_next   = '0;
               state_next = ON;
            end
         end

         default: begin
            state_next = IDLE;
            tone_next  = 1'b0;
            pre_next   = '0;
            div_next   = '0;
            ms_next    = '0;
            beep_next  = '0;
         end
      endcase
   end

   // State register and counters; reset clears everything immediately
   always_ff @(posedge clk_100MHz or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pre_cnt  <= '0;
         div_cnt  <= '0;
         ms_cnt   <= '0;
         beep_cnt <= '0;
      end else begin
         state    <= state_next;
         pre_cnt  <= pre_next;
         div_cnt  <= div_next;
         ms_cnt   <= ms_next;
         beep_cnt <= beep_next;
      end
   end

   // Sequence fields are captured only when a start is accepted in IDLE
   always_ff @(posedge clk_100MHz or negedge rst_n) begin
      if (!rst_n) begin
         half_lat <= '0;
         on_lat   <= '0;
         off_lat  <= '0;
      end else if (accept) begin
         half_lat <= half_eff;
         on_lat   <= on_eff;
         off_lat  <= i_off_ms;
      end
   end

   // Registered outputs so the speaker pin and status flags are glitch-free
   always_ff @(posedge clk_100MHz or negedge rst_n) begin
      if (!rst_n) begin
         o_tone <= 1'b0;
         o_busy <= 1'b0;
         o_done <= 1'b0;
      end else begin
         o_tone <= tone_next;
         o_busy <= (state_next != IDLE);
         o_done <= done_next;
      end
   end

endmodule

// File: tb/tb_pong_tone_seq.sv
// Testbench for pong_tone_seq: directed sequences with an event scoreboard.
// Stimulus pushes the expected output edges (edge number and kind) into a
// queue; the monitor turns every observed output edge into an event and
// removes the matching expectation. Leftover expectations are misses.
module tb_pong_tone_seq;

   localparam int CLK_HZ = 10_000;
   localparam int DIV_W  = 17;
   localparam int DUR_W  = 10;
   localparam int REP_W  = 3;
   localparam int M      = CLK_HZ / 1000;

   localparam int K_BUSY_RISE = 0;
   localparam int K_BUSY_FALL = 1;
   localparam int K_DONE_RISE = 2;
   localparam int K_DONE_FALL = 3;
   localparam int K_TONE_RISE = 4;
   localparam int K_TONE_FALL = 5;

   logic             clk_100MHz = 1'b0;
   logic             rst_n = 1'b0;
   logic             i_start = 1'b0;
   logic [DIV_W-1:0] i_half_period = '0;
   logic [DUR_W-1:0] i_on_ms = '0;
   logic [DUR_W-1:0] i_off_ms = '0;
   logic [REP_W-1:0] i_repeat = '0;
   logic             o_tone;
   logic             o_busy;
   logic             o_done;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;
   int exp_q[$];
   bit mon_en = 1'b0;
   logic prev_tone, prev_busy, prev_done;

   pong_tone_seq #(
      .CLK_HZ(CLK_HZ),
      .DIV_W (DIV_W),
      .DUR_W (DUR_W),
      .REP_W (REP_W)
   ) dut (
      .clk_100MHz   (clk_100MHz),
      .rst_n        (rst_n),
      .i_start      (i_start),
      .i_half_period(i_half_period),
      .i_on_ms      (i_on_ms),
      .i_off_ms     (i_off_ms),
      .i_repeat     (i_repeat),
      .o_tone       (o_tone),
      .o_busy       (o_busy),
      .o_done       (o_done)
   );

   // Free-running clock
   always #5 clk_100MHz = ~clk_100MHz;

   // Edge counter: after rising edge k, cyc == k
   always @(posedge clk_100MHz) cyc <= cyc + 1;

   function automatic string kindName(input int k);
      case (k)
         K_BUSY_RISE: return "busy_rise";
         K_BUSY_FALL: return "busy_fall";
         K_DONE_RISE: return "done_rise";
         K_DONE_FALL: return "done_fall";
         K_TONE_RISE: return "tone_rise";
         default:     return "tone_fall";
      endcase
   endfunction

   // Expected edges for one sequence whose start is sampled at edge t
   task automatic pushExpected(input int t, input int n, input int on, input int off, input int r);
      int ne, one, re, b, s, len, lvl;
      ne  = (n == 0) ? 1 : n;
      one = (on == 0) ? 1 : on;
      re  = (r == 0) ? 1 : r;
      b   = re * one * M + (re - 1) * off * M;
      exp_q.push_back(t * 8 + K_BUSY_RISE);
      exp_q.push_back((t + b) * 8 + K_BUSY_FALL);
      exp_q.push_back((t + b) * 8 + K_DONE_RISE);
      exp_q.push_back((t + b + 1) * 8 + K_DONE_FALL);
      for (int i = 0; i < re; i++) begin
         s   = t + i * (one + off) * M;
         len = one * M;
         lvl = 0;
         for (int k = ne; k < len; k += ne) begin
            exp_q.push_back((s + k) * 8 + ((lvl != 0) ? K_TONE_FALL : K_TONE_RISE));
            lvl = 1 - lvl;
         end
         if (lvl != 0) exp_q.push_back((s + len) * 8 + K_TONE_FALL);
      end
   endtask

   // Match one observed edge against the scoreboard
   task automatic observe(input int kind);
      int  key;
      bit  found;
      int  idx;
      key   = cyc * 8 + kind;
      found = 1'b0;
      idx   = 0;
      while (!found && idx < exp_q.size()) begin
         if (exp_q[idx] == key) begin
            exp_q.delete(idx);
            found = 1'b1;
         end else begin
            idx++;
         end
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("[TB] FAIL %s: observed at edge %0d, required none at this edge", kindName(kind), cyc);
      end
   endtask

   // Monitor: sample outputs on the falling edge and report every change
   always @(negedge clk_100MHz) begin
      if (mon_en) begin
         if (o_busy !== prev_busy) observe((o_busy === 1'b1) ? K_BUSY_RISE : K_BUSY_FALL);
         if (o_done !== prev_done) observe((o_done === 1'b1) ? K_DONE_RISE : K_DONE_FALL);
         if (o_tone !== prev_tone) observe((o_tone === 1'b1) ? K_TONE_RISE : K_TONE_FALL);
      end
      prev_busy = o_busy;
      prev_done = o_done;
      prev_tone = o_tone;
   end

   task automatic checkOutput(input string name, input logic [2:0] act, input logic [2:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("[TB] FAIL %s: got %b, required %b", name, act, req);
      end
   endtask

   // Issue a one-cycle start with the given fields; t is the sampling edge
   task automatic applyStimulus(input int n, input int on, input int off, input int r,
                                input bit model, output int t);
      @(negedge clk_100MHz);
      i_half_period = DIV_W'(n);
      i_on_ms       = DUR_W'(on);
      i_off_ms      = DUR_W'(off);
      i_repeat      = REP_W'(r);
      i_start       = 1'b1;
      t             = cyc + 1;
      if (model) pushExpected(t, n, on, off, r);
      @(negedge clk_100MHz);
      i_start = 1'b0;
   endtask

   initial begin
      int t;
      $display("[TB] pong_tone_seq bench start");

      // Reset state
      repeat (3) @(negedge clk_100MHz);
      checkOutput("reset_outputs", {o_tone, o_busy, o_done}, 3'b000);
      rst_n = 1'b1;
      repeat (2) @(negedge clk_100MHz);
      checkOutput("idle_after_release", {o_tone, o_busy, o_done}, 3'b000);
      mon_en = 1'b1;

      // Single 2 ms beep, N=3
      applyStimulus(3, 2, 0, 1, 1'b1, t);
      repeat (25) @(negedge clk_100MHz);

      // Three 1 ms beeps separated by 2 ms gaps, N=2
      applyStimulus(2, 1, 2, 3, 1'b1, t);
      repeat (75) @(negedge clk_100MHz);

      // All-zero fields promoted to 1 (gap ignored since only one beep)
      applyStimulus(0, 0, 3, 0, 1'b1, t);
      repeat (15) @(negedge clk_100MHz);

      // Second start while busy with different fields is ignored
      applyStimulus(3, 2, 0, 1, 1'b1, t);
      repeat (4) @(negedge clk_100MHz);
      i_half_period = DIV_W'(5);
      i_on_ms       = DUR_W'(7);
      i_off_ms      = DUR_W'(4);
      i_repeat      = REP_W'(6);
      i_start       = 1'b1;
      @(negedge clk_100MHz);
      i_start = 1'b0;
      repeat (25) @(negedge clk_100MHz);

      // Back-to-back beeps with no gap, odd toggle count forces tone low on re-entry
      applyStimulus(3, 1, 0, 2, 1'b1, t);
      repeat (25) @(negedge clk_100MHz);

      // Asynchronous reset in the middle of a sequence
      mon_en = 1'b0;
      applyStimulus(2, 1, 2, 3, 1'b0, t);
      repeat (6) @(negedge clk_100MHz);
      checkOutput("before_reset", {o_tone, o_busy, o_done}, 3'b110);
      #1 rst_n = 1'b0;
      #1 checkOutput("async_reset", {o_tone, o_busy, o_done}, 3'b000);
      @(negedge clk_100MHz);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_100MHz);
         checkOutput($sformatf("stay_idle_%0d", i), {o_tone, o_busy, o_done}, 3'b000);
      end
      mon_en = 1'b1;

      // Start held high: the next sequence is accepted in the done cycle
      @(negedge clk_100MHz);
      i_half_period = DIV_W'(3);
      i_on_ms       = DUR_W'(2);
      i_off_ms      = DUR_W'(0);
      i_repeat      = REP_W'(1);
      i_start       = 1'b1;
      t             = cyc + 1;
      pushExpected(t, 3, 2, 0, 1);
      pushExpected(t + 21, 3, 2, 0, 1);
      repeat (30) @(negedge clk_100MHz);
      i_start = 1'b0;
      repeat (25) @(negedge clk_100MHz);

      // Anything still expected was never seen
      mon_en = 1'b0;
      vectors++;
      foreach (exp_q[i]) begin
         miscompares++;
         $display("[TB] FAIL %s: not observed, required at edge %0d", kindName(exp_q[i] % 8), exp_q[i] / 8);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pong_tone_seq.md
# pong_tone_seq

Parametrised sound-effect sequencer for the Pong game. On a start pulse it plays a square-wave tone of programmable frequency as a burst of 1..2^REP_W-1 beeps, each with programmable on-time and gap in milliseconds, then signals completion. It sits between the game-logic event detector (paddle hit, wall hit, score) and the speaker/buzzer pin, replacing fixed-frequency tone dividers.

## Interface
- CLK_HZ, 100_000_000, input clock frequency; must be a multiple of 1000 and ≥ 1000
- DIV_W, 17, width of the half-period count
- DUR_W, 10, width of on/off durations in ms
- REP_W, 3, width of the beep count
- clk_100MHz  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- i_start  in  1  request a sequence; one-cycle pulse or level
- i_half_period  in  DIV_W  clock cycles per tone half-period, N; 0 treated as 1
- i_on_ms  in  DUR_W  beep length in ms; 0 treated as 1
- i_off_ms  in  DUR_W  gap between beeps in ms; 0 means no gap
- i_repeat  in  REP_W  number of beeps, R; 0 treated as 1
- o_tone  out  1  square-wave audio output
- o_busy  out  1  high while a sequence is running
- o_done  out  1  one-cycle pulse at sequence end

## Operation
- States: IDLE, ON, GAP.
- IDLE: o_tone=0, o_busy=0. When i_start=1, latch all i_* fields, clear the ms prescaler, divider, and ms counter, load the beep counter with R, and go to ON.
- While busy, i_start is ignored, and latched fields do not change.
- ms prescaler: counts 0..CLK_HZ/1000-1 and emits a tick on wrap. Width is $clog2(CLK_HZ/1000), minimum 1. It clears on every state entry.
- ON:
  - The divider counts 0..N-1, and o_tone toggles when it wraps.
  - o_tone is 0 and the divider is cleared on ON entry.
  - After on_ms ticks, decrement the beep counter.
  - If beeps remain and off_ms≠0, go to GAP.
  - If beeps remain and off_ms=0, re-enter ON with o_tone=0 and the divider cleared.
  - If no beeps remain, go to IDLE.
- GAP: o_tone=0. After off_ms ticks, go to ON.
- o_done: asserted for exactly one cycle, the first IDLE cycle after a completed sequence. A start accepted in that same cycle is honoured.
- Duration counter and beep counter are unsigned. Durations are counted in whole ms, so there is no accumulated rounding.

## Timing
- Reset values: o_tone=0, o_busy=0, o_done=0, state IDLE, all counters 0. These take effect immediately on rst_n low, including mid-sequence. After release, the block waits in IDLE for a new start.
- Let M=CLK_HZ/1000.
- Start sampled at edge t: o_busy=1 from edge t through edge t+B-1. B = R·on_ms·M + (R-1)·off_ms·M.
- o_done=1 for exactly the cycle after edge t+B. o_busy=0 in that cycle.
- In each ON phase starting at edge s, o_tone toggles at edges s+N, s+2N, … strictly before the phase ends, then is forced to 0 when ON exits.
- Latency from start to first tone edge is N cycles. Output is registered (glitch-free).

## Test plan
- CLK_HZ=10_000 (M=10), N=3, on_ms=2, off_ms=0, R=1, start at t0 -> o_busy high 20 cycles; o_tone toggles at t0+3,6,9,12,15,18; o_tone=0 after end; o_done pulses once at t0+21 cycle.
- M=10, N=2, on_ms=1, off_ms=2, R=3 -> o_busy high 70 cycles; o_tone active only in cycles [0,10), [30,40), [60,70), and 0 in the gaps; single o_done.
- N=0, on_ms=0, R=0 -> treated as 1/1/1: o_busy 10 cycles, o_tone toggles every cycle (5 high periods).
- Start pulsed again at cycle 5 of the scenario 1 run, with different fields -> ignored; the timing matches scenario 1 exactly.
- rst_n low at cycle 7 of scenario 2 -> o_tone, o_busy, o_done are 0 within the same cycle; after release with no start, everything stays 0.
- i_start held high continuously with scenario 1 settings -> the next sequence is accepted in the o_done cycle; the gap between busy periods is exactly 1 cycle.
